regfile_wb_queue: RTL

//  Write-side driver for the RV32I register file (rd/wen/wdata port). Buffers write-back

---
 rtl/regfile_wb_queue.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the RV32I register file: buffers write requests,
// drains one per cycle into the rd/wen/wdata port, and forwards pending data to decode.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int AW    = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_rd,
   input  logic [XLEN-1:0]          in_wdata,
   output logic [AW-1:0]            rd,
   output logic                     wen,
   output logic [XLEN-1:0]          wdata,
   input  logic [AW-1:0]            rs1,
   input  logic [AW-1:0]            rs2,
   output logic                     fwd1_hit,
   output logic [XLEN-1:0]          fwd1_data,
   output logic                     fwd2_hit,
   output logic [XLEN-1:0]          fwd2_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]   r_mem_rd   [DEPTH];
   logic [XLEN-1:0] r_mem_data [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   r_rd;
   logic            r_wen;
   logic [XLEN-1:0] r_wdata;

   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_f1_hit;
   logic [XLEN-1:0] w_f1_data;
   logic            w_f2_hit;
   logic [XLEN-1:0] w_f2_data;

   assign w_full = (r_count == CW'(DEPTH));
   assign w_push = in_valid && !w_full;
   assign w_pop  = (r_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_rd     <= '0;
         r_wen    <= 1'b0;
         r_wdata  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         // x0 entries still pass through the output stage, but never raise wen
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_rd     <= r_mem_rd[r_rd_ptr];
            r_wdata  <= r_mem_data[r_rd_ptr];
            r_wen    <= (r_mem_rd[r_rd_ptr] != '0);
         end else begin
            r_wen    <= 1'b0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rd[r_wr_ptr]   <= in_rd;
         r_mem_data[r_wr_ptr] <= in_wdata;
      end
   end

   // Scan oldest-to-newest so a younger match overrides an older one
   always_comb begin
      w_f1_hit  = r_wen && (rs1 != '0) && (r_rd == rs1);
      w_f1_data = w_f1_hit ? r_wdata : '0;
      w_f2_hit  = r_wen && (rs2 != '0) && (r_rd == rs2);
      w_f2_data = w_f2_hit ? r_wdata : '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < r_count) && (rs1 != '0) &&
             (r_mem_rd[r_rd_ptr + PW'(i)] == rs1)) begin
            w_f1_hit  = 1'b1;
            w_f1_data = r_mem_data[r_rd_ptr + PW'(i)];
         end
         if ((CW'(i) < r_count) && (rs2 != '0) &&
             (r_mem_rd[r_rd_ptr + PW'(i)] == rs2)) begin
            w_f2_hit  = 1'b1;
            w_f2_data = r_mem_data[r_rd_ptr + PW'(i)];
         end
      end
   end

   assign in_ready  = !w_full;
   assign rd        = r_rd;
   assign wen       = r_wen;
   assign wdata     = r_wdata;
   assign fwd1_hit  = w_f1_hit;
   assign fwd1_data = w_f1_data;
   assign fwd2_hit  = w_f2_hit;
   assign fwd2_data = w_f2_data;
   assign count     = r_count;
   assign empty     = (r_count == '0) && !r_wen;

endmodule
